// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: opcodes, instruction formats and ALU operation codes.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  // ALU codes are {ins[30], funct3}; only the ones the decoder names are listed.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  localparam logic [2:0] F3_SR = 3'b101;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate builder: assembles the I/S/B/U/J immediate and sign-extends it to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     ins_i,
  input  fmt_e            fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt_i)
      FMT_I: imm32 = {{20{ins_i[31]}}, ins_i[31:20]};
      FMT_S: imm32 = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
      FMT_B: imm32 = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
      FMT_U: imm32 = {ins_i[31:12], 12'b0};
      FMT_J: imm32 = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Fill the whole word with the sign first so XLEN=32 needs no zero-width replication.
  always_comb begin
    imm_o        = {XLEN{imm32[31]}};
    imm_o[31:0]  = imm32;
  end

endmodule

// File: rtl/decode_stage.sv
// Single-entry registered RV32I decode stage with valid/ready handshake, flush and illegal detection.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        ins,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         oprs1,
  output logic [4:0]         oprs2,
  output logic [4:0]         oprd,
  output logic [ALUOP_W-1:0] aluop,
  output logic [XLEN-1:0]    imm,
  output logic               wrt_en,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               branch,
  output logic               jump,
  output logic               illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  fmt_e       fmt;
  logic       known, bad_funct7;
  logic       wrt_raw, mrd_raw, mwr_raw, br_raw, jmp_raw;
  logic [3:0] alu4;

  logic               valid_q;
  logic [4:0]         rs1_q, rs2_q, rd_q;
  logic [4:0]         rs1_d, rs2_d, rd_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  logic               wrt_q, mrd_q, mwr_q, br_q, jmp_q, ill_q;
  logic               wrt_d, mrd_d, mwr_d, br_d, jmp_d, ill_d;
  logic               accept;

  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];

  always_comb begin
    fmt     = FMT_R;
    known   = 1'b1;
    wrt_raw = 1'b0;
    mrd_raw = 1'b0;
    mwr_raw = 1'b0;
    br_raw  = 1'b0;
    jmp_raw = 1'b0;
    alu4    = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        wrt_raw = 1'b1;
        alu4    = {ins[30], funct3};
      end
      OPC_OP_IMM: begin
        fmt     = FMT_I;
        wrt_raw = 1'b1;
        // Bit 30 is immediate data except for shifts, where it selects SRAI.
        alu4    = (funct3 == F3_SR) ? {ins[30], funct3} : {1'b0, funct3};
      end
      OPC_LOAD: begin
        fmt     = FMT_I;
        wrt_raw = 1'b1;
        mrd_raw = 1'b1;
      end
      OPC_STORE: begin
        fmt     = FMT_S;
        mwr_raw = 1'b1;
      end
      OPC_BRANCH: begin
        fmt    = FMT_B;
        br_raw = 1'b1;
        alu4   = {1'b0, funct3};
      end
      OPC_JAL: begin
        fmt     = FMT_J;
        wrt_raw = 1'b1;
        jmp_raw = 1'b1;
      end
      OPC_JALR: begin
        fmt     = FMT_I;
        wrt_raw = 1'b1;
        jmp_raw = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt     = FMT_U;
        wrt_raw = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  assign bad_funct7 = (opcode == OPC_OP) && (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
  assign ill_d      = !known || bad_funct7;

  always_comb begin
    rs1_d = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B) ? ins[19:15] : 5'd0;
    rs2_d = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) ? ins[24:20] : 5'd0;
    rd_d  = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) ? ins[11:7] : 5'd0;
  end

  assign wrt_d   = wrt_raw && (rd_d != 5'd0) && !ill_d;
  assign mrd_d   = mrd_raw && !ill_d;
  assign mwr_d   = mwr_raw && !ill_d;
  assign br_d    = br_raw && !ill_d;
  assign jmp_d   = jmp_raw && !ill_d;
  assign aluop_d = ALUOP_W'(alu4);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ins_i (ins[31:7]),
    .fmt_i (fmt),
    .imm_o (imm_d)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      aluop_q <= '0;
      imm_q   <= '0;
      wrt_q   <= 1'b0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      br_q    <= 1'b0;
      jmp_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      aluop_q <= aluop_d;
      imm_q   <= imm_d;
      wrt_q   <= wrt_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      br_q    <= br_d;
      jmp_q   <= jmp_d;
      ill_q   <= ill_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign oprs1     = rs1_q;
  assign oprs2     = rs2_q;
  assign oprd      = rd_q;
  assign aluop     = aluop_q;
  assign imm       = imm_q;
  assign wrt_en    = wrt_q;
  assign mem_rd    = mrd_q;
  assign mem_wr    = mwr_q;
  assign branch    = br_q;
  assign jump      = jmp_q;
  assign illegal   = ill_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath and immediate width (valid values 32 or 64).
REQ-002 The block SHALL have parameter ALUOP_W, default 4, meaning ALU operation code width.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  ins carries an instruction.
REQ-006 The block SHALL have port in_ready  output  1  block accepts ins this cycle.
REQ-007 The block SHALL have port ins  input  32  raw RV32I instruction word.
REQ-008 The block SHALL have port flush  input  1  discard the held instruction.
REQ-009 The block SHALL have port out_valid  output  1  decoded fields valid.
REQ-010 The block SHALL have port out_ready  input  1  downstream consumes the decoded fields.
REQ-011 The block SHALL have ports oprs1, oprs2, oprd  output  5 each  register indices.
REQ-012 The block SHALL have port aluop  output  ALUOP_W  ALU operation.
REQ-013 The block SHALL have port imm  output  XLEN  sign-extended immediate.
REQ-014 The block SHALL have ports wrt_en, mem_rd, mem_wr, branch, jump, illegal  output  1 each  control flags.

Function
REQ-015 Decode SHALL cover opcodes OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC; the immediate SHALL be formed per I/S/B/U/J format and sign-extended from ins[31] to XLEN.
REQ-016 Outputs SHALL be registered: an instruction accepted at edge N (in_valid && in_ready) SHALL appear on the outputs with out_valid=1 after edge N, giving a latency of 1.
REQ-017 in_ready SHALL equal !out_valid || out_ready, making the stage full-throughput with no bubble under continuous flow.
REQ-018 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-019 flush SHALL clear out_valid at the next edge and SHALL override a simultaneous accept, so the flushed-cycle instruction is dropped.
REQ-020 aluop for OP SHALL be {ins[30],funct3}.
REQ-021 aluop for OP-IMM SHALL be {ins[30],funct3} when funct3=101, and {0,funct3} otherwise.
REQ-022 aluop for BRANCH SHALL be {0,funct3}; for every other opcode it SHALL be 0000 (ADD).
REQ-023 wrt_en SHALL be 1 for OP, OP-IMM, LOAD, JAL, JALR, LUI and AUIPC, and SHALL be forced to 0 when oprd=0.
REQ-024 mem_rd SHALL be 1 only for LOAD; mem_wr SHALL be 1 only for STORE; branch SHALL be 1 only for BRANCH; jump SHALL be 1 only for JAL and JALR.
REQ-025 Fields a format does not use (oprs2 for I-type, oprd for S/B-type, imm for R-type) SHALL be driven to 0.
REQ-026 illegal SHALL be 1 for an unknown opcode, or for OP with funct7 other than 0000000/0100000; in that case wrt_en, mem_rd, mem_wr, branch and jump SHALL be 0, and the instruction SHALL still flow with out_valid=1.

Reset
REQ-027 On rst, out_valid, all register indices, aluop, imm and all flags SHALL reset to 0 at the next edge.
REQ-028 rst SHALL take priority over flush and accept; an instruction in flight during reset SHALL be lost.

Structure
REQ-029 A shared package decode_pkg SHALL hold the opcode constants, a format enum (R/I/S/B/U/J) and the aluop constants.
REQ-030 Immediate generation SHALL be a combinational sub-module imm_gen, parameterised by XLEN.

Verification
REQ-031 ins=0xFFF00093 (addi x1,x0,-1) -> one cycle later: oprd=1, oprs1=0, imm=0xFFFFFFFF, aluop=0000, wrt_en=1.
REQ-032 ins=0x402081B3 (sub x3,x1,x2) -> oprs1=1, oprs2=2, oprd=3, aluop=1000, imm=0.
REQ-033 ins=0x0020A423 (sw x2,8(x1)) -> imm=8, mem_wr=1, wrt_en=0; ins=0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, branch=1, wrt_en=0.
REQ-034 Back-to-back valid instructions with out_ready=0 for 3 cycles -> in_ready=0 and outputs constant throughout, then resume with nothing lost or duplicated.
REQ-035 ins=0x0000007F -> illegal=1 with all other control flags 0.
REQ-036 flush asserted together with an accept -> out_valid=0 next cycle; rst asserted mid-stall -> all outputs 0 next cycle.
